generator_ctrl: RTL
===================

// Module: generator_ctrl
// PURPOSE
//   Sequencer/configurator for the 2-3-9 generator MLP. Loads all 45 weight/bias words from a
//   serial config stream into registers driving the generator's flattened w/b buses, then runs
//   one inference per accepted (a_1,a_2) pair. Waits SETTLE cycles for the combinational generator
//   to settle, captures its 9 outputs and presents them on a valid/ready output port.
// PARAMETERS
//   WIDTH        32  signed word width (inputs, weights, biases, outputs)
//   N_INPUT      2   layer-2 fan-in
//   N_NEURON_L2  3   layer-2 neurons (= layer-3 fan-in)
//   N_NEURON_L3  9   layer-3 neurons (= outputs)
//   SETTLE       2   cycles from operand latch to output capture, >=1
// PORTS
//   clk        in   1                  clock, all state on rising edge
//   rst        in   1                  synchronous active-high reset
//   cfg_valid  in   1                  config word valid
//   cfg_ready  out  1                  config word accepted when valid&ready
//   cfg_data   in   WIDTH              config word (signed)
//   cfg_done   out  1                  1-cycle pulse after the last (45th) word is written
//   configured out  1                  high once a full load has completed; cleared by rst only
//   in_valid   in   1                  operand pair valid
//   in_ready   out  1                  operand pair accepted when valid&ready
//   in_a_1     in   WIDTH              operand a_1
//   in_a_2     in   WIDTH              operand a_2
//   gen_a_1    out  WIDTH              to generator a_1 (registered)
//   gen_a_2    out  WIDTH              to generator a_2 (registered)
//   gen_w_L2   out  N_INPUT*N_NEURON_L2*WIDTH      to generator w_L2
//   gen_b_L2   out  N_NEURON_L2*WIDTH              to generator b_L2
//   gen_w_L3   out  N_NEURON_L2*N_NEURON_L3*WIDTH  to generator w_L3
//   gen_b_L3   out  N_NEURON_L3*WIDTH              to generator b_L3
//   gen_y      in   N_NEURON_L3*WIDTH  generator outputs packed, y_1x1 in [WIDTH-1:0] .. y_3x3 on top
//   out_valid  out  1                  result valid, held until out_ready
//   out_ready  in   1                  downstream accepts result
//   out_y      out  N_NEURON_L3*WIDTH  captured result, same packing as gen_y
// BEHAVIOUR
//   Reset: state UNCFG, word counter 0, all gen_* regs 0, out_y 0, out_valid 0, cfg_done 0,
//     configured 0. rst mid-load or mid-inference aborts; partial load discarded (regs zeroed).
//   Config order (word k = 0..44, each written to slice k of its bus, lowest slice first):
//     k 0-5 w_L2[0..5], 6-8 b_L2[0..2], 9-35 w_L3[0..26], 36-44 b_L3[0..8].
//   States: UNCFG, LOAD, IDLE, SETTLE, OUT.
//   UNCFG: cfg_ready=1, in_ready=0. Accepted word -> written as k=0, counter=1, -> LOAD.
//   LOAD: cfg_ready=1, in_ready=0. Each accepted word written at counter, counter++. Word 44
//     accepted -> counter 0, cfg_done=1 next cycle, configured=1, -> IDLE. Gaps in cfg_valid ok.
//   IDLE: cfg_ready=1; in_ready = !cfg_valid (config has priority on simultaneous valids).
//     Accepted cfg word -> reload begins as in UNCFG (configured stays 1, outputs undefined
//     until reload done). Accepted operand -> gen_a_1/gen_a_2 latched, settle counter=SETTLE-1,
//     -> SETTLE.
//   SETTLE: cfg_ready=0, in_ready=0. Counter 0 -> out_y <= gen_y, out_valid=1, -> OUT; else decr.
//     out_valid rises exactly SETTLE cycles after the operand accept edge.
//   OUT: cfg_ready=0, in_ready=0; out_y/out_valid stable while !out_ready. out_ready high ->
//     out_valid=0 next cycle, -> IDLE. No new operand accepted in the release cycle.
//   Throughput: one inference per SETTLE+2 cycles best case. No arithmetic in this block;
//     all words pass through unmodified (signed, no truncation). gen_a_* hold last operand.
// TESTING (bench uses stub generator: y_n = a_1 + n, n=0..8)
//   Reset: hold rst 2 cycles -> all outputs 0, cfg_ready=1, in_ready=0, configured=0.
//   Load words 100..144 back-to-back -> cfg_done pulses once after 45th; w_L2 slice0=100,
//     b_L2 slice0=106, w_L3 slice26=135, b_L3 slice8=144; configured=1.
//   Inference a_1=5,a_2=-3, out_ready=1 -> out_valid SETTLE(2) cycles after accept, out_y
//     slices = 5..13; in_ready returns 1 cycle after release.
//   Backpressure: out_ready=0 for 10 cycles -> out_y stable, in_valid ignored; then release.
//   Simultaneous cfg_valid & in_valid in IDLE -> cfg word taken, in_ready=0, state LOAD.
//   rst asserted after 20 cfg words -> all w/b regs 0, configured=0, next word lands at k=0.

Source files
------------

// File: rtl/generator_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : generator_ctrl
// Description : Sequencer/configurator for the 2-3-9 generator MLP.
//               Loads all weight/bias words from a serial config stream into
//               registers that drive the generator's flattened w/b buses, then
//               runs one inference per accepted (a_1, a_2) operand pair. After
//               SETTLE cycles the combinational generator outputs are captured
//               and presented on a valid/ready result port.
// Ports       : clk, rst                    clock / synchronous active-high reset
//               cfg_valid/cfg_ready/cfg_data serial config word stream
//               cfg_done                    1-cycle pulse after the last word
//               configured                  sticky "a full load has completed"
//               in_valid/in_ready/in_a_1/in_a_2  operand pair handshake
//               gen_a_1/gen_a_2             registered operands to generator
//               gen_w_L2/gen_b_L2/gen_w_L3/gen_b_L3  weight/bias buses
//               gen_y                       generator outputs (combinational)
//               out_valid/out_ready/out_y   captured result handshake
// Revision    : 1.0 - initial release
// ============================================================================
module generator_ctrl #(
    parameter int WIDTH       = 32,
    parameter int N_INPUT     = 2,
    parameter int N_NEURON_L2 = 3,
    parameter int N_NEURON_L3 = 9,
    parameter int SETTLE      = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [WIDTH-1:0]                       cfg_data,
    output logic                                   cfg_done,
    output logic                                   configured,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [WIDTH-1:0]                       in_a_1,
    input  logic [WIDTH-1:0]                       in_a_2,
    output logic [WIDTH-1:0]                       gen_a_1,
    output logic [WIDTH-1:0]                       gen_a_2,
    output logic [N_INPUT*N_NEURON_L2*WIDTH-1:0]   gen_w_L2,
    output logic [N_NEURON_L2*WIDTH-1:0]           gen_b_L2,
    output logic [N_NEURON_L2*N_NEURON_L3*WIDTH-1:0] gen_w_L3,
    output logic [N_NEURON_L3*WIDTH-1:0]           gen_b_L3,
    input  logic [N_NEURON_L3*WIDTH-1:0]           gen_y,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [N_NEURON_L3*WIDTH-1:0]           out_y
);

    // Word counts of each bus, in config-stream order.
    localparam int c_N_W_L2 = N_INPUT * N_NEURON_L2;
    localparam int c_N_B_L2 = N_NEURON_L2;
    localparam int c_N_W_L3 = N_NEURON_L2 * N_NEURON_L3;
    localparam int c_N_B_L3 = N_NEURON_L3;
    localparam int c_N_CFG  = c_N_W_L2 + c_N_B_L2 + c_N_W_L3 + c_N_B_L3;
    localparam int c_CW     = $clog2(c_N_CFG);
    localparam int c_SW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [c_CW-1:0] c_LAST_WORD  = c_CW'(c_N_CFG - 1);
    localparam logic [c_SW-1:0] c_SETTLE_INI = c_SW'(SETTLE - 1);

    // Bit offsets of each bus inside the flat config register.
    localparam int c_OFF_B_L2 = c_N_W_L2 * WIDTH;
    localparam int c_OFF_W_L3 = c_OFF_B_L2 + c_N_B_L2 * WIDTH;
    localparam int c_OFF_B_L3 = c_OFF_W_L3 + c_N_W_L3 * WIDTH;

    typedef enum logic [2:0] {
        c_UNCFG  = 3'd0,
        c_LOAD   = 3'd1,
        c_IDLE   = 3'd2,
        c_SETTLE = 3'd3,
        c_OUT    = 3'd4
    } state_t;

    state_t                          r_state_q,      w_state_d;
    logic [c_CW-1:0]                 r_cnt_q,        w_cnt_d;
    logic [c_SW-1:0]                 r_settle_q,     w_settle_d;
    // Config word k lives at bits [k*WIDTH +: WIDTH]; the stream order matches
    // the concatenation w_L2 | b_L2 | w_L3 | b_L3, so each bus is a plain slice.
    logic [c_N_CFG*WIDTH-1:0]        r_cfg_q,        w_cfg_d;
    logic [WIDTH-1:0]                r_a_1_q,        w_a_1_d;
    logic [WIDTH-1:0]                r_a_2_q,        w_a_2_d;
    logic [N_NEURON_L3*WIDTH-1:0]    r_out_y_q,      w_out_y_d;
    logic                            r_out_valid_q,  w_out_valid_d;
    logic                            r_cfg_done_q,   w_cfg_done_d;
    logic                            r_configured_q, w_configured_d;

    logic                            w_cfg_ready;
    logic                            w_in_ready;

    always_comb begin
        w_state_d      = r_state_q;
        w_cnt_d        = r_cnt_q;
        w_settle_d     = r_settle_q;
        w_cfg_d        = r_cfg_q;
        w_a_1_d        = r_a_1_q;
        w_a_2_d        = r_a_2_q;
        w_out_y_d      = r_out_y_q;
        w_out_valid_d  = r_out_valid_q;
        w_cfg_done_d   = 1'b0;
        w_configured_d = r_configured_q;
        w_cfg_ready    = 1'b0;
        w_in_ready     = 1'b0;

        case (r_state_q)
            c_UNCFG, c_LOAD, c_IDLE: begin
                w_cfg_ready = 1'b1;
                // Config wins over an operand presented in the same cycle.
                w_in_ready  = (r_state_q == c_IDLE) && !cfg_valid;
                if (cfg_valid) begin
                    // Counter is 0 in UNCFG/IDLE, so a (re)load starts at word 0.
                    for (int k = 0; k < c_N_CFG; k++) begin
                        if (r_cnt_q == c_CW'(k)) begin
                            w_cfg_d[k*WIDTH +: WIDTH] = cfg_data;
                        end
                    end
                    if (r_cnt_q == c_LAST_WORD) begin
                        w_cnt_d        = '0;
                        w_cfg_done_d   = 1'b1;
                        w_configured_d = 1'b1;
                        w_state_d      = c_IDLE;
                    end else begin
                        w_cnt_d   = r_cnt_q + c_CW'(1);
                        w_state_d = c_LOAD;
                    end
                end else if (w_in_ready && in_valid) begin
                    w_a_1_d    = in_a_1;
                    w_a_2_d    = in_a_2;
                    w_settle_d = c_SETTLE_INI;
                    w_state_d  = c_SETTLE;
                end
            end
            c_SETTLE: begin
                if (r_settle_q == '0) begin
                    w_out_y_d     = gen_y;
                    w_out_valid_d = 1'b1;
                    w_state_d     = c_OUT;
                end else begin
                    w_settle_d = r_settle_q - c_SW'(1);
                end
            end
            c_OUT: begin
                if (out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_state_d     = c_IDLE;
                end
            end
            default: begin
                w_state_d = c_UNCFG;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= c_UNCFG;
            r_cnt_q        <= '0;
            r_settle_q     <= '0;
            r_cfg_q        <= '0;
            r_a_1_q        <= '0;
            r_a_2_q        <= '0;
            r_out_y_q      <= '0;
            r_out_valid_q  <= 1'b0;
            r_cfg_done_q   <= 1'b0;
            r_configured_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_settle_q     <= w_settle_d;
            r_cfg_q        <= w_cfg_d;
            r_a_1_q        <= w_a_1_d;
            r_a_2_q        <= w_a_2_d;
            r_out_y_q      <= w_out_y_d;
            r_out_valid_q  <= w_out_valid_d;
            r_cfg_done_q   <= w_cfg_done_d;
            r_configured_q <= w_configured_d;
        end
    end

    assign cfg_ready  = w_cfg_ready;
    assign in_ready   = w_in_ready;
    assign cfg_done   = r_cfg_done_q;
    assign configured = r_configured_q;
    assign gen_a_1    = r_a_1_q;
    assign gen_a_2    = r_a_2_q;
    assign gen_w_L2   = r_cfg_q[0          +: c_N_W_L2*WIDTH];
    assign gen_b_L2   = r_cfg_q[c_OFF_B_L2 +: c_N_B_L2*WIDTH];
    assign gen_w_L3   = r_cfg_q[c_OFF_W_L3 +: c_N_W_L3*WIDTH];
    assign gen_b_L3   = r_cfg_q[c_OFF_B_L3 +: c_N_B_L3*WIDTH];
    assign out_valid  = r_out_valid_q;
    assign out_y      = r_out_y_q;

endmodule
`default_nettype wire
